// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and stall controller for a five-stage in-order core.
// Handles load-use bubbles, taken-branch flushes, data-memory wait and HALT.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ifid_rs,
  input  logic [2:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [2:0]       idex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt_id,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             back_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_next;
  logic   luh;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign luh = idex_mem_read & (idex_rd != 3'd0) &
               ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Flushing IF/ID always drops its enable so the NOP load wins.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    back_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    state_next = state;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            back_en    = 1'b0;
            state_next = MEMWAIT;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_next = FLUSH;
          end else if (luh) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (halt_id) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            state_next = HALT;
          end
        end
        MEMWAIT: begin
          if (mem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            back_en = 1'b0;
          end else begin
            state_next = RUN;
          end
        end
        FLUSH: begin
          if (mem_busy) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            back_en    = 1'b0;
            state_next = MEMWAIT;
          end else begin
            ifid_flush = 1'b1;
            ifid_en    = 1'b0;
            state_next = RUN;
          end
        end
        HALT: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          halted     = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; a CNT_W=4 copy shares the
// stimulus to exercise counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ifid_rs, ifid_rt, idex_rd;
  logic        ifid_uses_rt, idex_mem_read, branch_taken, mem_busy, halt_id;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, back_en, halted;
  logic [15:0] stall_cnt;
  logic        pc_en4, ifid_en4, ifid_flush4, idex_flush4, back_en4, halted4;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .halt_id(halt_id),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .back_en(back_en), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .halt_id(halt_id),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .back_en(back_en4), .halted(halted4), .stall_cnt(stall_cnt4)
  );

  task automatic idle_inputs();
    ifid_rs = 3'd0; ifid_rt = 3'd0; ifid_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_rd = 3'd0;
    branch_taken = 1'b0; mem_busy = 1'b0; halt_id = 1'b0;
  endtask

  // Advance one edge; leave time 1 after the edge so inputs change off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; mem_busy = 1'b1; branch_taken = 1'b1; halt_id = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_en, back_en, ifid_flush, idex_flush, halted} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 111000",
               {pc_en, ifid_en, back_en, ifid_flush, idex_flush, halted});
    end
    tick(); tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    end
    rst = 1'b0; idle_inputs();
    #1;
    checks++;
    if ({pc_en, ifid_en, back_en, ifid_flush, idex_flush, halted} !== 6'b111000) begin
      errors++;
      $display("FAIL run_idle_outputs: got %b expected 111000",
               {pc_en, ifid_en, back_en, ifid_flush, idex_flush, halted});
    end
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_load_use();
    idex_mem_read = 1'b1; idex_rd = 3'd3; ifid_rs = 3'd3;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush, back_en} !== 4'b0011) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected 0011", {pc_en, ifid_en, idex_flush, back_en});
    end
    tick();
    exp_cnt = 1;
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    idle_inputs();
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin
      errors++; $display("FAIL load_use_single: got %b expected 110", {pc_en, ifid_en, idex_flush});
    end
    tick();
  endtask

  task automatic test_reg0_and_rt();
    idex_mem_read = 1'b1; idex_rd = 3'd0; ifid_rs = 3'd0; ifid_rt = 3'd0; ifid_uses_rt = 1'b1;
    #1;
    checks++;
    if ({pc_en, idex_flush} !== 2'b10) begin
      errors++; $display("FAIL reg0_no_stall: got %b expected 10", {pc_en, idex_flush});
    end
    tick();
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL reg0_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    idex_rd = 3'd5; ifid_rs = 3'd2; ifid_rt = 3'd5; ifid_uses_rt = 1'b0;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL rt_unused: got pc_en=%b expected 1", pc_en);
    end
    ifid_uses_rt = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin
      errors++; $display("FAIL rt_hazard: got %b expected 001", {pc_en, ifid_en, idex_flush});
    end
    tick();
    exp_cnt = 2;
    idle_inputs();
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1011) begin
      errors++;
      $display("FAIL branch_cycle: got %b expected 1011", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1010) begin
      errors++;
      $display("FAIL flush_state: got %b expected 1010", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    tick();
    #1;
    checks++;
    if ({ifid_en, ifid_flush} !== 2'b10) begin
      errors++; $display("FAIL back_to_run: got %b expected 10", {ifid_en, ifid_flush});
    end
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mem_branch();
    mem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_en, ifid_en, back_en, ifid_flush, idex_flush} !== 5'b00000) begin
        errors++;
        $display("FAIL mem_freeze[%0d]: got %b expected 00000", i,
                 {pc_en, ifid_en, back_en, ifid_flush, idex_flush});
      end
      tick();
    end
    exp_cnt += 3;
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL mem_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if ({pc_en, back_en, ifid_flush, idex_flush} !== 4'b1100) begin
      errors++;
      $display("FAIL mem_release: got %b expected 1100", {pc_en, back_en, ifid_flush, idex_flush});
    end
    tick();
    #1;
    checks++;
    if ({ifid_flush, idex_flush} !== 2'b11) begin
      errors++; $display("FAIL branch_after_mem: got %b expected 11", {ifid_flush, idex_flush});
    end
    tick();
    branch_taken = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL mem_branch_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_halt_reset();
    halt_id = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush, halted} !== 4'b0000) begin
      errors++;
      $display("FAIL halt_issue: got %b expected 0000", {pc_en, ifid_en, idex_flush, halted});
    end
    tick();
    exp_cnt += 1;
    halt_id = 1'b0; mem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({pc_en, ifid_en, back_en, idex_flush, ifid_flush, halted} !== 6'b001101) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %b expected 001101", i,
                 {pc_en, ifid_en, back_en, idex_flush, ifid_flush, halted});
      end
      tick();
    end
    exp_cnt += 4;
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL halt_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_en, halted} !== 2'b10) begin
      errors++; $display("FAIL halt_rst_outputs: got %b expected 10", {pc_en, halted});
    end
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if ({pc_en, halted, stall_cnt} !== {2'b10, 16'd0}) begin
      errors++;
      $display("FAIL halt_rst_state: got pc_en=%b halted=%b cnt=%0d expected 1 0 0",
               pc_en, halted, stall_cnt);
    end
    tick();
  endtask

  task automatic test_reset_memwait();
    mem_busy = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_en, back_en} !== 2'b11) begin
      errors++; $display("FAIL memwait_rst_outputs: got %b expected 11", {pc_en, back_en});
    end
    tick();
    rst = 1'b0; mem_busy = 1'b0; branch_taken = 1'b1;
    #1;
    checks++;
    if ({ifid_flush, idex_flush, stall_cnt} !== {2'b11, 16'd0}) begin
      errors++;
      $display("FAIL memwait_rst_run: got flush=%b cnt=%0d expected 11 0",
               {ifid_flush, idex_flush}, stall_cnt);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (stall_cnt4 !== 4'd15) begin
      errors++; $display("FAIL sat_cnt4: got %0d expected 15", stall_cnt4);
    end
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_cnt16: got %0d expected 20", stall_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall_cnt4 !== 4'd0) begin
      errors++; $display("FAIL sat_rst: got %0d expected 0", stall_cnt4);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_reg0_and_rt();
    test_branch();
    test_mem_branch();
    test_halt_reset();
    test_reset_memwait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
